// File: rtl/conv_pkg.sv
// conv_pkg
// Shared types and constants for the 2x2 convolution window generator and
// the neuron stage that consumes its windows.
//   PIX_W    : width of one pixel in bits
//   pixel_t  : signed two's-complement pixel
//   window_t : four packed pixels, [3]=up-left, [2]=up, [1]=left, [0]=current
package conv_pkg;

   localparam int PIX_W = 8;

   typedef logic signed [PIX_W-1:0] pixel_t;
   typedef logic [3:0][PIX_W-1:0]   window_t;

   // Number of complete 2x2 windows one frame of w x h pixels yields.
   function automatic int windowsPerFrame(input int w, input int h);
      return (w - 1) * (h - 1);
   endfunction

endpackage

// File: rtl/conv_window_gen_if.sv
// conv_window_gen_if
// Bundles the pixel input handshake and the window output handshake of the
// window generator.
//   pix_in/in_valid/in_ready/sof : raster-order pixel stream, sof marks (0,0)
//   pixels/win_valid/out_ready   : 2x2 window stream to the neuron stage
// Modports:
//   slave  : the window generator's view
//   master : the pixel producer / window consumer side
interface conv_window_gen_if;
   import conv_pkg::*;

   pixel_t  pix_in;
   logic    in_valid;
   logic    in_ready;
   logic    sof;
   window_t pixels;
   logic    win_valid;
   logic    out_ready;

   modport slave (
      input  pix_in,
      input  in_valid,
      input  sof,
      input  out_ready,
      output in_ready,
      output pixels,
      output win_valid
   );

   modport master (
      output pix_in,
      output in_valid,
      output sof,
      output out_ready,
      input  in_ready,
      input  pixels,
      input  win_valid
   );

endinterface

// File: rtl/conv_line_buf.sv
// conv_line_buf
// Shift-register line buffer holding the most recent DEPTH accepted pixels.
// With DEPTH equal to the row width, the oldest entry is the pixel directly
// above the one being shifted in.
//   clk        : clock
//   shiftEn_i  : shift din_i in this cycle
//   din_i      : pixel to store
//   tap_o      : oldest stored pixel
// Contents are not reset; stale entries are overwritten by row 0 of a new
// frame before any window uses them.
module conv_line_buf
   import conv_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic   clk,
   input  logic   shiftEn_i,
   input  pixel_t din_i,
   output pixel_t tap_o
);

   pixel_t mem_q [DEPTH];

   // Every accepted pixel enters at entry 0 and ages one slot per accept.
   always_ff @(posedge clk) begin
      if (shiftEn_i) begin
         mem_q[0] <= din_i;
         for (int i = 1; i < DEPTH; i++) begin
            mem_q[i] <= mem_q[i-1];
         end
      end
   end

   assign tap_o = mem_q[DEPTH-1];

endmodule

// File: rtl/conv_window_gen.sv
// conv_window_gen
// Turns a raster-order pixel stream into a stream of 2x2 windows, one per
// accepted pixel at row>=1 and col>=1, with one cycle of latency and a single
// output register (full throughput when the consumer is always ready).
//   IMG_W, IMG_H : image width and height in pixels (both >= 2)
//   clk, rst     : clock and asynchronous active-high reset
//   stream       : pixel input and window output handshakes
module conv_window_gen
   import conv_pkg::*;
#(
   parameter int IMG_W = 8,
   parameter int IMG_H = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   conv_window_gen_if.slave         stream
);

   localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_H - 1);

   logic             accept;
   logic             windowPos;
   logic             colAtEnd;
   logic             rowAtEnd;
   logic [COL_W-1:0] curCol, col_d, col_q;
   logic [ROW_W-1:0] curRow, row_d, row_q;
   pixel_t           tapPix;
   pixel_t           left_q;
   pixel_t           upLeft_q;
   window_t          pixels_d, pixels_q;
   logic             winValid_d, winValid_q;

   // The single output register can take a new window when it is empty or
   // is being emptied this cycle.
   assign stream.in_ready  = !winValid_q || stream.out_ready;
   assign accept           = stream.in_valid && stream.in_ready;
   assign stream.pixels    = pixels_q;
   assign stream.win_valid = winValid_q;

   conv_line_buf #(
      .DEPTH(IMG_W)
   ) u_lineBuf (
      .clk      (clk),
      .shiftEn_i(accept),
      .din_i    (stream.pix_in),
      .tap_o    (tapPix)
   );

   // Position of the pixel being accepted: sof forces (0,0), otherwise the
   // stored counters already point at the next expected position. The
   // counters then advance from that position so a mid-frame sof restarts
   // counting from the sof pixel.
   always_comb begin
      curCol   = stream.sof ? '0 : col_q;
      curRow   = stream.sof ? '0 : row_q;
      colAtEnd = (curCol == LAST_COL);
      rowAtEnd = (curRow == LAST_ROW);
      col_d    = col_q;
      row_d    = row_q;
      if (accept) begin
         if (colAtEnd) begin
            col_d = '0;
            row_d = rowAtEnd ? '0 : curRow + ROW_W'(1);
         end else begin
            col_d = curCol + COL_W'(1);
            row_d = curRow;
         end
      end
   end

   // A window exists only once a full pixel above and a full pixel to the
   // left are available. Loading a new window takes priority over clearing,
   // which lets a consume and a new window share a cycle without a bubble.
   always_comb begin
      windowPos  = (curRow != '0) && (curCol != '0);
      winValid_d = winValid_q;
      pixels_d   = pixels_q;
      if (accept && windowPos) begin
         winValid_d  = 1'b1;
         pixels_d[3] = upLeft_q;
         pixels_d[2] = tapPix;
         pixels_d[1] = left_q;
         pixels_d[0] = stream.pix_in;
      end else if (stream.out_ready) begin
         winValid_d = 1'b0;
      end
   end

   // Counters and the output window are the only reset state; reset drops
   // any pending window and makes the next accepted pixel (0,0).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_q      <= '0;
         row_q      <= '0;
         winValid_q <= 1'b0;
         pixels_q   <= '0;
      end else begin
         col_q      <= col_d;
         row_q      <= row_d;
         winValid_q <= winValid_d;
         pixels_q   <= pixels_d;
      end
   end

   // Neighbour registers: left_q is the previous accepted pixel and
   // upLeft_q the previous line-buffer tap, giving p(r,c-1) and p(r-1,c-1)
   // for the next accept. Stale values only ever pair with col 0, which
   // never forms a window.
   always_ff @(posedge clk) begin
      if (accept) begin
         left_q   <= stream.pix_in;
         upLeft_q <= tapPix;
      end
   end

endmodule
